// File: rtl/edge_cache_ctrl_pkg.sv
// Shared constants and state encoding for the
// edge-weight cache sequencer.
package edge_cache_ctrl_pkg;

  localparam int DEFAULT_VALUE_WIDTH = 16;
  localparam int EDGE_NODE_BITS = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_SERVE = 2'd3
  } state_t;

endpackage

// File: rtl/edge_cache_if.sv
// Loader stream and dual read-requester bus
// of the edge-weight cache controller.
interface edge_cache_if
  import edge_cache_ctrl_pkg::*;
#(
  parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH,
  parameter int NODE_BITS   = EDGE_NODE_BITS
);

  logic                   ld_valid;
  logic                   ld_ready;
  logic [NODE_BITS-1:0]   ld_from;
  logic [NODE_BITS-1:0]   ld_to;
  logic [VALUE_WIDTH-1:0] ld_weight;
  logic                   ld_last;

  logic [1:0]             rd_req;
  logic [2*NODE_BITS-1:0] rd_from;
  logic [2*NODE_BITS-1:0] rd_to;
  logic [1:0]             rd_gnt;
  logic [1:0]             rd_rvalid;
  logic [VALUE_WIDTH-1:0] rd_data;

  modport master (
    output ld_valid,
    output ld_from,
    output ld_to,
    output ld_weight,
    output ld_last,
    output rd_req,
    output rd_from,
    output rd_to,
    input  ld_ready,
    input  rd_gnt,
    input  rd_rvalid,
    input  rd_data
  );

  modport slave (
    input  ld_valid,
    input  ld_from,
    input  ld_to,
    input  ld_weight,
    input  ld_last,
    input  rd_req,
    input  rd_from,
    input  rd_to,
    output ld_ready,
    output rd_gnt,
    output rd_rvalid,
    output rd_data
  );

endinterface

// File: rtl/edge_cache_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer only
// moves when both requesters contend.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (en && (&req)) begin
      ptr <= ~ptr;
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/edge_cache_ctrl.sv
// Clear/load sequencer and read arbiter in front
// of the single-port edge-weight cache RAM.
module edge_cache_ctrl
  import edge_cache_ctrl_pkg::*;
#(
  parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH,
  parameter int NODE_BITS   = EDGE_NODE_BITS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   cache_valid,
  edge_cache_if.slave            bus,
  output logic [2*NODE_BITS-1:0] mem_address,
  output logic                   mem_write_enable,
  output logic [VALUE_WIDTH-1:0] mem_write_data,
  input  logic [VALUE_WIDTH-1:0] mem_edge_value
);

  localparam int AW = 2 * NODE_BITS;

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] clr_cnt;
  logic [1:0]    gnt;
  logic [1:0]    rvalid;
  logic          arb_en;
  logic          ld_fire;

  logic [NODE_BITS-1:0] from0, from1;
  logic [NODE_BITS-1:0] to0, to1;

  assign from0 = bus.rd_from[NODE_BITS-1:0];
  assign from1 = bus.rd_from[AW-1:NODE_BITS];
  assign to0   = bus.rd_to[NODE_BITS-1:0];
  assign to1   = bus.rd_to[AW-1:NODE_BITS];

  assign ld_fire = (state == ST_LOAD) && bus.ld_valid;

  // start in SERVE pre-empts any grant that cycle
  assign arb_en = (state == ST_SERVE) && !start;

  rr_arbiter2 u_arb (
    .clock (clock),
    .reset (reset),
    .en    (arb_en),
    .req   (bus.rd_req),
    .gnt   (gnt)
  );

  assign bus.rd_gnt    = gnt;
  assign bus.rd_rvalid = rvalid;
  assign bus.rd_data   = mem_edge_value;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
    end else begin
      clr_cnt <= '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rvalid <= 2'b00;
    end else begin
      rvalid <= gnt;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (&clr_cnt) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        if (ld_fire && bus.ld_last)
          state_nx = ST_SERVE;
      end
      ST_SERVE: begin
        if (start) state_nx = ST_CLEAR;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy             = 1'b0;
    cache_valid      = 1'b0;
    bus.ld_ready     = 1'b0;
    mem_address      = '0;
    mem_write_enable = 1'b0;
    mem_write_data   = '0;
    unique case (state)
      ST_CLEAR: begin
        busy             = 1'b1;
        mem_write_enable = 1'b1;
        mem_address      = clr_cnt;
        mem_write_data   = '1;
      end
      ST_LOAD: begin
        bus.ld_ready = 1'b1;
        if (bus.ld_valid) begin
          mem_write_enable = 1'b1;
          mem_address      = {bus.ld_to, bus.ld_from};
          mem_write_data   = bus.ld_weight;
        end
      end
      ST_SERVE: begin
        cache_valid = 1'b1;
        unique case (1'b1)
          gnt[0]:  mem_address = {to0, from0};
          gnt[1]:  mem_address = {to1, from1};
          default: mem_address = '0;
        endcase
      end
      default: ;
    endcase
  end

endmodule
